fp_operand_loader: RTL

- Writer side of the FP adder operand memory.
- Accepts a byte stream over a valid/ready handshake and assembles operand pairs (A, B), each an IEEE-754 single.
- Writes each pair into the operand RAM at consecutive addresses, which the FP adder system later reads one entry per en step.
- Signals done after NUM pairs so the adder system can be enabled.

---
 rtl/fp_operand_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fp_operand_loader.sv
// fp_operand_loader: byte-stream writer for the FP adder operand RAM.
// Optional 9th checksum byte per entry: define CHECKSUM_EN.
module fp_operand_loader #(
    parameter int NUM    = 10,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata_a,
    output logic [DATA_W-1:0] mem_wdata_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHK,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM - 1);
    localparam int SH_W = 2 * DATA_W;

    state_t          state;
    state_t          nstate;
    logic            armed;
    logic [2:0]      bcnt;
    logic [SH_W-1:0] sh;
    logic [SH_W-1:0] sh_nx;
    logic            go;

    // start is ignored on the first edge after reset release
    assign go    = start && armed;
    assign sh_nx = {sh[SH_W-9:0], byte_in};

`ifdef CHECKSUM_EN
    logic       ck_ok;
    logic [7:0] ck_x;

    // XOR of the eight buffered data bytes against the incoming byte
    always_comb begin
        ck_x = 8'h00;
        for (int i = 0; i < SH_W / 8; i++) begin
            ck_x = ck_x ^ sh[8*i +: 8];
        end
        ck_ok = (ck_x == byte_in);
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // next state and handshake/status outputs
    always_comb begin
        nstate     = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) nstate = S_RECV;
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && bcnt == 3'd7) begin
`ifdef CHECKSUM_EN
                    nstate = S_CHK;
`else
                    nstate = S_WRITE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    nstate = ck_ok ? S_WRITE : S_RECV;
                end
            end
`endif
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                nstate = (count == LAST) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done = 1'b1;
                if (go) nstate = S_RECV;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // byte assembly, write-port registers and entry counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed       <= 1'b0;
            bcnt        <= 3'd0;
            sh          <= '0;
            count       <= '0;
            mem_addr    <= '0;
            mem_wdata_a <= '0;
            mem_wdata_b <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        count <= '0;
                        bcnt  <= 3'd0;
                        sh    <= '0;
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        sh   <= sh_nx;
                        bcnt <= bcnt + 3'd1;
`ifndef CHECKSUM_EN
                        if (bcnt == 3'd7) begin
                            mem_wdata_a <= sh_nx[SH_W-1:DATA_W];
                            mem_wdata_b <= sh_nx[DATA_W-1:0];
                            mem_addr    <= count;
                        end
`endif
                    end
                end
`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (byte_valid) begin
                        bcnt <= 3'd0;
                        if (ck_ok) begin
                            mem_wdata_a <= sh[SH_W-1:DATA_W];
                            mem_wdata_b <= sh[DATA_W-1:0];
                            mem_addr    <= count;
                        end
                    end
                end
`endif
                S_WRITE: begin
                    count <= count + ADDR_W'(1);
                    bcnt  <= 3'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic err_q;

    // sticky checksum error, cleared only by a new session
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE || state == S_DONE) && go) begin
            err_q <= 1'b0;
        end else if (state == S_CHK && byte_valid && !ck_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
